// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns LDR/STR into single-word req/ack
// transactions, stalling the pipeline while an access is outstanding.
module mem_stage #(
  parameter int unsigned BASE_ADDR  = 1024,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [31:0]           alu_res_in,
  input  logic [31:0]           val_rm_in,
  input  logic [3:0]            dest_in,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic [31:0]           alu_res_out,
  output logic [31:0]           mem_res_out,
  output logic [3:0]            dest_out,
  output logic                  freeze,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic                  mem_err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  access;

  assign access = mem_r_en_in | mem_w_en_in;

  // Non-memory controls and results flow straight through
  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en_in;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

  // Stall starts in the same cycle the access is seen so EXE holds its operands
  assign freeze = ((state_q == IDLE) && access) || (state_q == BUSY);

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_res_out = rdata_q;
  assign mem_err     = mem_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_err_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            addr_q    <= ADDR_WIDTH'((alu_res_in - 32'(BASE_ADDR)) >> 2);
            wdata_q   <= val_rm_in;
            mem_we_q  <= mem_w_en_in;
            mem_req_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!mem_we_q) rdata_q <= mem_rdata;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Abandon after TIMEOUT unanswered cycles and poison the read value
            mem_err_q <= 1'b1;
            rdata_q   <= 32'hDEADBEEF;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed accesses push expectations,
// a monitor checks the memory port and each completed access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_res_out;
  logic [3:0]  dest_out;
  logic        freeze, mem_req, mem_we, mem_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  logic        resp_ack = 1'b0;
  logic        ack_force = 1'b0;
  int          ack_wait = 1000;
  int          wcnt = 0;
  logic [31:0] rdata_v = '0;
  logic        mon_on = 1'b0;
  int          fcnt = 0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] res;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  assign mem_ack   = resp_ack | ack_force;
  assign mem_rdata = rdata_v;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_res_out(mem_res_out), .dest_out(dest_out),
    .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Memory model: ack in the (ack_wait+1)-th cycle of a request
  always @(negedge clk) begin
    if (!mem_req) begin
      resp_ack <= 1'b0;
      wcnt     <= 0;
    end else begin
      resp_ack <= (wcnt == ack_wait);
      wcnt     <= wcnt + 1;
    end
  end

  // Monitor: request fields every request cycle, result when the stall ends
  always @(negedge clk) begin
    if (!mon_on) begin
      fcnt = 0;
    end else begin
      if (mem_req) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got mem_req=1, expected no request");
        end else begin
          check("req_addr",  32'(mem_addr), 32'(sbq[0].addr));
          check("req_we",    32'(mem_we),   32'(sbq[0].we));
          check("req_wdata", mem_wdata,     sbq[0].wdata);
        end
      end
      if (freeze) begin
        fcnt++;
      end else if (fcnt > 0) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got stall of %0d, expected none", fcnt);
        end else begin
          e = sbq.pop_front();
          check("stall_cycles", 32'(fcnt), 32'(e.stalls));
          check("done_res",     mem_res_out, e.res);
          check("done_err",     32'(mem_err), 32'(e.err));
          check("done_req",     32'(mem_req), 32'(0));
          check("done_we",      32'(mem_we),  32'(0));
        end
        fcnt = 0;
      end
    end
  end

  task automatic clear_in();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_res_in = '0; val_rm_in = '0; dest_in = '0;
  endtask

  // Presents one memory instruction and returns in the IDLE cycle after DONE
  task automatic access(input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] val, input logic [31:0] rdata, input int wait_n,
                        input logic [15:0] ea, input logic ewe, input logic [31:0] eres,
                        input logic eerr, input int estalls);
    exp_t x;
    int k;
    x.addr = ea; x.we = ewe; x.wdata = val; x.res = eres; x.err = eerr; x.stalls = estalls;
    sbq.push_back(x);
    rdata_v = rdata; ack_wait = wait_n;
    wb_en_in = r; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_rm_in = val; dest_in = 4'h5;
    k = 0;
    do begin
      @(posedge clk); #2;
      k++;
    end while (freeze && k < 400);
    if (freeze) begin
      total++; bad++;
      $display("FAIL access_bound: got freeze still high after %0d cycles, expected release", k);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req",   32'(mem_req),   32'(0));
    check("rst_we",    32'(mem_we),    32'(0));
    check("rst_err",   32'(mem_err),   32'(0));
    check("rst_freeze",32'(freeze),    32'(0));
    check("rst_addr",  32'(mem_addr),  32'(0));
    check("rst_wdata", mem_wdata,      32'h0);
    check("rst_res",   mem_res_out,    32'h0);
    @(negedge clk) rst = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #2;

    // Non-memory instruction passes through without stalling
    wb_en_in = 1; alu_res_in = 32'h12345678; dest_in = 4'h3;
    #1;
    check("pt_alu",    alu_res_out,        32'h12345678);
    check("pt_dest",   32'(dest_out),      32'h3);
    check("pt_wb",     32'(wb_en_out),     32'h1);
    check("pt_ren",    32'(mem_r_en_out),  32'h0);
    check("pt_freeze", 32'(freeze),        32'h0);
    repeat (3) begin
      @(posedge clk); #2;
      check("pt_noreq", 32'(mem_req), 32'h0);
    end
    clear_in();
    @(posedge clk); #2;

    // Read, ack in first BUSY cycle
    access(1, 0, 32'd1032, 32'h0, 32'hCAFEF00D, 0, 16'd2, 1'b0, 32'hCAFEF00D, 1'b0, 2);
    clear_in();
    @(posedge clk); #2;
    // Write, ack after 3 BUSY cycles; read register untouched
    access(0, 1, 32'd1064, 32'hA5A5A5A5, 32'h77777777, 2, 16'd10, 1'b1, 32'hCAFEF00D, 1'b0, 4);
    // Back-to-back loads
    access(1, 0, 32'd1024, 32'h0, 32'h11111111, 0, 16'd0, 1'b0, 32'h11111111, 1'b0, 2);
    access(1, 0, 32'd1028, 32'h0, 32'h22222222, 0, 16'd1, 1'b0, 32'h22222222, 1'b0, 2);
    // Both enables: write wins
    access(1, 1, 32'd1124, 32'h5A5A0001, 32'h33333333, 1, 16'd25, 1'b1, 32'h22222222, 1'b0, 3);
    clear_in();
    @(posedge clk); #2;
    // Timeout
    access(1, 0, 32'd1028, 32'h0, 32'h44444444, 1000, 16'd1, 1'b0, 32'hDEADBEEF, 1'b1, 16);
    clear_in();
    @(posedge clk); #2;
    check("to_idle_freeze", 32'(freeze),  32'h0);
    check("to_idle_req",    32'(mem_req), 32'h0);
    check("to_err_sticky",  32'(mem_err), 32'h1);

    // Reset during BUSY, then a stray ack
    mon_on = 1'b0;
    ack_wait = 1000;
    mem_r_en_in = 1; alu_res_in = 32'd1040;
    repeat (3) @(posedge clk);
    #2;
    check("busy_req_before_rst", 32'(mem_req), 32'h1);
    clear_in();
    rst = 1'b0;
    #1;
    check("rst_busy_req", 32'(mem_req),  32'h0);
    check("rst_busy_res", mem_res_out,   32'h0);
    check("rst_busy_err", 32'(mem_err),  32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #2;
    ack_force = 1'b1;
    @(posedge clk); #2;
    ack_force = 1'b0;
    repeat (2) begin
      check("late_ack_req",    32'(mem_req), 32'h0);
      check("late_ack_freeze", 32'(freeze),  32'h0);
      check("late_ack_res",    mem_res_out,  32'h0);
      @(posedge clk); #2;
    end
    check("sb_drained", 32'(sbq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
